// File: rtl/fc_ctrl.sv
// fc_ctrl: sequencing controller for a fully-connected layer datapath (P=1).
//
// Loads an M-word input vector into the x-memory, then for each of N rows
// streams x-memory/weight-ROM reads, drives the MAC accumulator through a
// LAT-deep tag pipeline, captures the row result and offers it downstream.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   input_valid / input_ready    upstream stream (word consumed on handshake)
//   output_valid / output_ready  downstream stream (one handshake per row)
//   x_wr_en, x_addr              x-memory write strobe / address
//   w_addr, rd_en                weight-ROM address, shared read strobe
//   acc_first, acc_en            accumulator load/add control
//   out_ld                       capture accumulator into output register
//   stall_cnt                    only with FC_CTRL_STALLCNT_EN defined:
//                                saturating count of output stall cycles
//
// Build option: define FC_CTRL_STALLCNT_EN to add the stall_cnt port.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_LOAD  | accept input words, write x-memory at k
// S_ISSUE | one read per cycle, x_addr=k, w_addr=n*M+k
// S_DRAIN | wait LAT+1 cycles for the pipeline; out_ld in the last one
// S_OUT   | output_valid held until output_ready

module fc_ctrl #(
  parameter int M       = 16,
  parameter int N       = 12,
  parameter int MUL_LAT = 1,
  parameter int XA      = $clog2(M),
  parameter int WA      = $clog2(M*N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          input_valid,
  output logic          input_ready,
  output logic          output_valid,
  input  logic          output_ready,
  output logic          x_wr_en,
  output logic [XA-1:0] x_addr,
  output logic [WA-1:0] w_addr,
  output logic          rd_en,
  output logic          acc_first,
  output logic          acc_en,
`ifdef FC_CTRL_STALLCNT_EN
  output logic [31:0]   stall_cnt,
`endif
  output logic          out_ld
);

  localparam int LAT = 1 + MUL_LAT;
  localparam int NA  = (N > 1) ? $clog2(N) : 1;
  localparam int DW  = $clog2(LAT + 1);

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t          state;
  logic [XA-1:0]   k;
  logic [NA-1:0]   n;
  logic [DW-1:0]   dcnt;
  logic [LAT-1:0]  p_rd;
  logic [LAT-1:0]  p_first;
  logic [LAT-1:0]  p_last;
  logic            ld_q;

  // Gated by reset_n so nothing is written or offered while reset is held.
  assign input_ready  = reset_n && (state == S_LOAD);
  assign x_wr_en      = input_ready && input_valid;
  assign rd_en        = (state == S_ISSUE);
  assign output_valid = (state == S_OUT);
  assign x_addr       = k;
  assign w_addr       = WA'(int'(n) * M + int'(k));
  assign acc_en       = p_rd[LAT-1];
  assign acc_first    = p_first[LAT-1];
  assign out_ld       = ld_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_LOAD;
      k     <= '0;
      n     <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (input_valid) begin
            if (k == XA'(M - 1)) begin
              k     <= '0;
              n     <= '0;
              state <= S_ISSUE;
            end else begin
              k <= k + XA'(1);
            end
          end
        end
        S_ISSUE: begin
          if (k == XA'(M - 1)) begin
            k     <= '0;
            dcnt  <= DW'(LAT);
            state <= S_DRAIN;
          end else begin
            k <= k + XA'(1);
          end
        end
        S_DRAIN: begin
          // down-counter: LAT..0 gives LAT+1 cycles in DRAIN
          if (dcnt == '0) state <= S_OUT;
          else            dcnt  <= dcnt - DW'(1);
        end
        S_OUT: begin
          if (output_ready) begin
            if (n == NA'(N - 1)) begin
              n     <= '0;
              state <= S_LOAD;
            end else begin
              n     <= n + NA'(1);
              state <= S_ISSUE;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Tags ride alongside the read so the accumulator controls line up with
  // the data after memory read latency plus multiplier stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_rd    <= '0;
      p_first <= '0;
      p_last  <= '0;
      ld_q    <= 1'b0;
    end else begin
      p_rd[0]    <= rd_en;
      p_first[0] <= rd_en && (k == '0);
      p_last[0]  <= rd_en && (k == XA'(M - 1));
      for (int i = 1; i < LAT; i++) begin
        p_rd[i]    <= p_rd[i-1];
        p_first[i] <= p_first[i-1];
        p_last[i]  <= p_last[i-1];
      end
      ld_q <= p_last[LAT-1];
    end
  end

`ifdef FC_CTRL_STALLCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (output_valid && !output_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fc_ctrl.sv
// tb_fc_ctrl: scoreboard bench for fc_ctrl. A behavioural datapath
// (x-memory, weight ROM, one multiplier stage, accumulator, output register)
// is driven by the DUT controls; expected row results are pushed when a
// vector is issued and popped by the monitor on each output handshake.

module tb_fc_ctrl;

  localparam int M   = 16;
  localparam int N   = 12;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       input_valid = 1'b0;
  logic       output_ready = 1'b0;
  logic       input_ready, output_valid, x_wr_en, rd_en, acc_first, acc_en, out_ld;
  logic [3:0] x_addr;
  logic [7:0] w_addr;
`ifdef FC_CTRL_STALLCNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 0;
  int stall_left = 0;
  int in_data = 0;
  int exp_q[$];

  fc_ctrl #(.M(M), .N(N), .MUL_LAT(1)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .input_valid(input_valid),
    .input_ready(input_ready),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .x_wr_en(x_wr_en),
    .x_addr(x_addr),
    .w_addr(w_addr),
    .rd_en(rd_en),
    .acc_first(acc_first),
    .acc_en(acc_en),
`ifdef FC_CTRL_STALLCNT_EN
    .stall_cnt(stall_cnt),
`endif
    .out_ld(out_ld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int wfun(input int a);
    return ((a * 5 + 3) % 11) - 5;
  endfunction

  // behavioural datapath
  int x_mem[M];
  int xd, wd, prod, acc, out_reg;
  always @(posedge clk) begin
    if (x_wr_en) x_mem[x_addr] <= in_data;
    if (rd_en) begin
      xd <= x_mem[x_addr];
      wd <= wfun(int'(w_addr));
    end
    prod <= xd * wd;
    if (acc_en) acc <= acc_first ? prod : acc + prod;
    if (out_ld) out_reg <= acc;
  end

  // output_ready driver: 0 always ready, 1 random, 2 stall row 3 for 5 cycles
  int row_idx = 0;
  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      case (mode)
        1: output_ready = 1'($urandom_range(0, 1));
        2: begin
          if (output_valid && row_idx == 3 && stall_left > 0) begin
            output_ready = 1'b0;
            stall_left--;
          end else begin
            output_ready = 1'b1;
          end
        end
        default: output_ready = 1'b1;
      endcase
    end
  end

  // monitor
  int ld_k = 0, kk = 0, row_start = 0;
  int acc_cnt = 0, first_cnt = 0, ld_cnt = 0, rd_cnt = 0;
  int row_stall = 0, tb_stall = 0;
  bit ov_prev = 0, hs_prev = 0, rd_prev = 0, seen_ov = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      row_idx = 0; ld_k = 0; kk = 0; row_start = 0;
      acc_cnt = 0; first_cnt = 0; ld_cnt = 0; rd_cnt = 0;
      row_stall = 0; tb_stall = 0;
      ov_prev = 0; hs_prev = 0; rd_prev = 0; seen_ov = 0;
    end else begin
      if (x_wr_en) begin
        chk("wr_in_load", input_ready, 1);
        chk("wr_addr", x_addr, ld_k);
        ld_k = (ld_k + 1) % M;
      end
      if (rd_en && !rd_prev) begin
        row_start = cyc; kk = 0;
        acc_cnt = 0; first_cnt = 0; ld_cnt = 0; rd_cnt = 0;
        seen_ov = 0; row_stall = 0;
      end
      if (rd_en) begin
        chk("w_addr", w_addr, row_idx * M + kk);
        chk("x_addr_rd", x_addr, kk);
        kk++;
        rd_cnt++;
      end
      if (acc_en) begin
        acc_cnt++;
        chk("acc_window", (cyc - row_start >= LAT) && (cyc - row_start <= LAT + M - 1), 1);
      end
      if (acc_first) begin
        first_cnt++;
        chk("first_align", cyc - row_start, LAT);
        chk("first_with_en", acc_en, 1);
      end
      if (out_ld) begin
        ld_cnt++;
        chk("out_ld_cycle", cyc - row_start, M + LAT);
      end
      if (ov_prev && !hs_prev) chk("ov_hold", output_valid, 1);
      if (output_valid) begin
        chk("no_rd_in_out", rd_en, 0);
        if (!seen_ov) begin
          seen_ov = 1;
          chk("ov_latency", cyc - row_start, M + LAT + 1);
        end
        if (!output_ready) begin
          row_stall++;
          tb_stall++;
        end else begin
          chk("acc_cnt", acc_cnt, M);
          chk("first_cnt", first_cnt, 1);
          chk("ld_cnt", ld_cnt, 1);
          chk("rd_cnt", rd_cnt, M);
          if (mode == 2 && row_idx == 3) chk("stall_len", row_stall, 5);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL result: unexpected output row %0d, value %0d", row_idx, out_reg);
          end else begin
            chk("result", out_reg, exp_q.pop_front());
          end
          row_idx = (row_idx == N - 1) ? 0 : row_idx + 1;
        end
      end
      ov_prev = output_valid;
      hs_prev = output_valid && output_ready;
      rd_prev = rd_en;
    end
  end

  task automatic send_vector(input int v[M], input bit rnd, output int t0);
    int n_wait;
    t0 = -1;
    for (int i = 0; i < M; i++) begin
      if (rnd && $urandom_range(0, 1) == 1) begin
        input_valid = 1'b0;
        @(posedge clk); #1;
      end
      input_valid = 1'b1;
      in_data = v[i];
      n_wait = 0;
      while (!input_ready && n_wait < 2000) begin
        @(posedge clk); #1;
        n_wait++;
      end
      if (!input_ready) begin
        checks++;
        failures++;
        $display("FAIL input_timeout: word %0d not accepted, got ready %0d expected 1", i, input_ready);
        input_valid = 1'b0;
        return;
      end
      if (i == 0) t0 = cyc;
      @(posedge clk); #1;
    end
    input_valid = 1'b0;
    for (int r = 0; r < N; r++) begin
      int s;
      s = 0;
      for (int c = 0; c < M; c++) s += v[c] * wfun(r * M + c);
      exp_q.push_back(s);
    end
  endtask

  task automatic wait_load(output int c);
    int n_wait;
    n_wait = 0;
    while (!input_ready && n_wait < 5000) begin
      @(posedge clk); #1;
      n_wait++;
    end
    if (!input_ready) begin
      checks++;
      failures++;
      $display("FAIL load_timeout: got ready %0d expected 1", input_ready);
    end
    c = cyc;
  endtask

  int vec_a[M], vec_b[M], vec_c[M], vec_d[M], vec_e[M], vec_f[M];
  int t0, t1, n_wait;

  initial begin
    for (int i = 0; i < M; i++) begin
      vec_a[i] = i - 8;
      vec_b[i] = ((i * 3) % 7) - 3;
      vec_c[i] = 1;
      vec_d[i] = (i % 2 == 0) ? 5 : -4;
      vec_e[i] = 15 - 2 * i;
      vec_f[i] = (i * i) % 9 - 4;
    end

    // reset state, input_valid asserted to confirm no write leaks through
    repeat (3) @(posedge clk);
    #1;
    input_valid = 1'b1;
    #1;
    chk("rst_input_ready", input_ready, 0);
    chk("rst_x_wr_en", x_wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_out_valid", output_valid, 0);
    chk("rst_w_addr", w_addr, 0);
    input_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_input_ready", input_ready, 1);
    chk("rel_x_addr", x_addr, 0);

    // layer 1: ready always high, full-layer timing
    mode = 0;
    send_vector(vec_a, 1'b0, t0);
    chk("issue_ready_low", input_ready, 0);
    chk("issue_started", rd_en, 1);
    wait_load(t1);
    chk("layer_cycles", t1 - t0, M + N * (M + LAT + 2));

    // layer 2: row 3 output stalled for 5 cycles
    mode = 2;
    stall_left = 5;
    send_vector(vec_b, 1'b0, t0);
    wait_load(t1);
    chk("stall_consumed", stall_left, 0);
`ifdef FC_CTRL_STALLCNT_EN
    chk("stall_cnt", stall_cnt, 5);
`endif

    // layer 3: reset during ISSUE of row 7 at k=9
    mode = 0;
    send_vector(vec_c, 1'b0, t0);
    n_wait = 0;
    while (!(rd_en && w_addr == 8'(7 * M + 9)) && n_wait < 2000) begin
      @(posedge clk); #1;
      n_wait++;
    end
    chk("row7_k9_reached", n_wait < 2000, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_acc_en", acc_en, 0);
    chk("mid_rst_acc_first", acc_first, 0);
    chk("mid_rst_out_ld", out_ld, 0);
    chk("mid_rst_out_valid", output_valid, 0);
    chk("mid_rst_input_ready", input_ready, 0);
    chk("mid_rst_x_addr", x_addr, 0);
    chk("mid_rst_w_addr", w_addr, 0);
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", input_ready, 1);
`ifdef FC_CTRL_STALLCNT_EN
    chk("post_rst_stall_cnt", stall_cnt, 0);
`endif
    input_valid = 1'b1;
    in_data = vec_d[0];
    #1;
    chk("post_rst_wr", x_wr_en, 1);
    chk("post_rst_addr", x_addr, 0);
    send_vector(vec_d, 1'b0, t0);
    wait_load(t1);
    chk("post_rst_layer_cycles", t1 - t0, M + N * (M + LAT + 2));

    // layers 4-5: random input gaps and output backpressure
    mode = 1;
    send_vector(vec_e, 1'b1, t0);
    send_vector(vec_f, 1'b1, t0);
    wait_load(t1);
    mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fc_ctrl.md
Name: fc_ctrl

Overview:
- Control unit for the fully-connected layer datapath (fc_M_N_T_R_P family, P=1).
- Accepts an M-element input vector over a valid/ready stream and writes it into the x-memory.
- Sequences the x-memory/weight-ROM reads and the MAC accumulator for each of N output rows.
- Presents each finished row to the downstream valid/ready stream, then returns to loading.

Parameters:
- M, 16, input vector length (x-memory depth).
- N, 12, output vector length (number of rows).
- MUL_LAT, 1, register stages in the multiplier between memory data-out and the accumulator.
- XA, $clog2(M), x-memory address width (derived).
- WA, $clog2(M*N), weight-ROM address width (derived).

Ports:
- clk  in  1  clock, all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- input_valid  in  1  upstream data valid.
- input_ready  out  1  controller accepts an input word.
- output_valid  out  1  output register holds a valid row result.
- output_ready  in  1  downstream accepts the result.
- x_wr_en  out  1  write x-memory at x_addr with input_data.
- x_addr  out  XA  x-memory address (write in LOAD, read in ISSUE).
- w_addr  out  WA  weight-ROM read address.
- rd_en  out  1  read strobe to x-memory and weight ROM.
- acc_first  out  1  accumulator loads the product instead of adding.
- acc_en  out  1  accumulator update enable.
- out_ld  out  1  capture accumulator into output register.

Behaviour:
- Reset (async assert, sync-style deassert on clk): state=LOAD; counters k and n = 0; delay pipeline cleared; every output 0 except input_ready=1 once reset_n=1. Reset mid-operation discards the partial vector and row; the next accepted word is written to address 0.
- LAT = 1 + MUL_LAT: memory read latency 1 plus multiplier stages.
- States: LOAD, ISSUE, DRAIN, OUT.
- LOAD: input_ready=1 and x_addr=k.
  - x_wr_en = input_valid (combinational).
  - On handshake k++. On the handshake with k==M-1: k<=0, n<=0, go to ISSUE. No handshake: hold.
- ISSUE: rd_en=1, x_addr=k, w_addr=n*M+k; k++ every cycle, with no stall.
  - At k==M-1: k<=0, go to DRAIN.
  - input_ready=0 in every state other than LOAD.
- Delay pipeline: rd_en, (k==0) and (k==M-1) tags are shifted through LAT registers.
  - acc_en = delayed rd_en.
  - acc_first = delayed (k==0) tag.
  - out_ld asserts one cycle after the acc_en carrying the (k==M-1) tag.
- DRAIN: lasts LAT+1 cycles; out_ld is asserted in its final cycle, then go to OUT.
- OUT: output_valid=1, held stable until output_ready.
  - On handshake: if n==N-1, go to LOAD with n<=0; else n++ and go to ISSUE.
  - output_valid deasserts the cycle after the handshake.
- Per-row timing (ISSUE start = cycle 0): acc_en cycles LAT..LAT+M-1; out_ld cycle M+LAT; output_valid from cycle M+LAT+1. With M=16, MUL_LAT=1: acc_en cycles 2-17, out_ld 18, output_valid 19.
- Row throughput = M+LAT+2 cycles when output_ready is held high.
- w_addr wraps only through the n/k resets and never exceeds M*N-1. x_addr never exceeds M-1.
- input_valid while not in LOAD is ignored; the word is not consumed.
- output_ready while output_valid=0 has no effect.

Optional Feature:
- Macro: FC_CTRL_STALLCNT_EN.
- Defined: adds output port stall_cnt [31:0].
  - Increments every cycle with output_valid=1 and output_ready=0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by reset_n.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then input_valid held 1 for 16 cycles (M=16): x_wr_en on 16 consecutive cycles with x_addr 0..15; input_ready drops the cycle after the 16th handshake; ISSUE begins that cycle.
- Row 0 with output_ready=1: w_addr 0..15 over 16 cycles; acc_first exactly once, aligned with the first acc_en; 16 acc_en pulses; out_ld once; output_valid high one cycle, 19 cycles after ISSUE start.
- Full layer with output_ready always 1: 12 output handshakes with w_addr bases 0,16,...,176; then input_ready=1 again; total 16+12*20 cycles from first input handshake to return to LOAD.
- output_ready held 0 for 5 cycles on row 3: output_valid stays 1 and no rd_en until the handshake; with FC_CTRL_STALLCNT_EN, stall_cnt reads 5.
- reset_n pulsed low during ISSUE of row 7 (k=9): all outputs 0 immediately; after release, input_ready=1 and the next word writes x_addr 0.
- Random input_valid/output_ready gaps (50%): ordered outputs equal fc_16_12_20_0_1 reference vectors; no x_wr_en outside LOAD; no acc_en outside the LAT window.
